// File: rtl/psum_accum_pp_pkg.sv
// rtl/psum_accum_pp_pkg.sv - shared types and helpers for the ping-pong psum accumulator
package psum_accum_pp_pkg;

  typedef enum logic [1:0] {ACC1, ACCN, FLUSH, SWAP} acc_state_e;

  typedef enum logic {BANK_PING = 1'b0, BANK_PONG = 1'b1} bank_e;

  // Width that holds NPE PE values plus the fed-back psum without overflow.
  function automatic int sum_width(input int dwidth, input int npe);
    return dwidth + $clog2(npe + 1);
  endfunction

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_PING) ? BANK_PONG : BANK_PING;
  endfunction

endpackage

// File: rtl/psum_accum_pp_if.sv
// rtl/psum_accum_pp_if.sv - PE-side, drain-side and status signals of the accumulator (PSUM_SAT_EN adds sat_hit)
interface psum_accum_pp_if #(
  parameter int DWIDTH = 32,
  parameter int NPE    = 3
);
  logic                    data_valid;
  logic                    in_ready;
  logic                    ic_done;
  logic                    oc_done;
  logic [NPE*DWIDTH-1:0]   pe_data;
  logic                    result_valid;
  logic                    result_ready;
  logic [DWIDTH-1:0]       result;
  logic                    acc_bank;
  logic                    err_ovf;
  logic                    err_unf;
  logic                    err_clr;
`ifdef PSUM_SAT_EN
  logic                    sat_hit;
`endif

  modport master (
    output data_valid, ic_done, oc_done, pe_data, result_ready, err_clr,
`ifdef PSUM_SAT_EN
    input  sat_hit,
`endif
    input  in_ready, result_valid, result, acc_bank, err_ovf, err_unf
  );

  modport slave (
    input  data_valid, ic_done, oc_done, pe_data, result_ready, err_clr,
`ifdef PSUM_SAT_EN
    output sat_hit,
`endif
    output in_ready, result_valid, result, acc_bank, err_ovf, err_unf
  );

endinterface

// File: rtl/psum_accum_pp_addtree.sv
// rtl/psum_accum_pp_addtree.sv - NPE-input plus psum adder with ADD_LAT pipeline (PSUM_SAT_EN saturates)
module psum_accum_pp_addtree
  import psum_accum_pp_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int NPE     = 3,
  parameter int ADD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [NPE*DWIDTH-1:0] pe_data,
  input  logic [DWIDTH-1:0]     psum_in,
  output logic                  out_valid,
`ifdef PSUM_SAT_EN
  output logic                  out_sat,
`endif
  output logic [DWIDTH-1:0]     out_data
);
  // Wrapping arithmetic modulo 2**DWIDTH gives the same low bits as the
  // full-precision tree, so the wide tree is only built when saturating.
`ifdef PSUM_SAT_EN
  localparam int SW = sum_width(DWIDTH, NPE);
`else
  localparam int SW = DWIDTH;
`endif

  logic [SW-1:0]     sum_full;
  logic [DWIDTH-1:0] sum_res;

  // Sign-extend every operand to the tree width and add them up.
  always_comb begin
    sum_full = SW'($signed(psum_in));
    for (int i = 0; i < NPE; i++) begin
      sum_full = sum_full + SW'($signed(pe_data[i*DWIDTH +: DWIDTH]));
    end
  end

`ifdef PSUM_SAT_EN
  logic               sum_sat;
  logic [ADD_LAT-1:0] sat_q;

  // Clamp when the bits above the DWIDTH sign bit disagree with the true sign.
  always_comb begin
    sum_sat = (sum_full[SW-1:DWIDTH-1] != {(SW-DWIDTH+1){sum_full[SW-1]}});
    if (!sum_sat)            sum_res = sum_full[DWIDTH-1:0];
    else if (sum_full[SW-1]) sum_res = {1'b1, {(DWIDTH-1){1'b0}}};
    else                     sum_res = {1'b0, {(DWIDTH-1){1'b1}}};
  end

  // Saturation flag travels alongside its sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_q <= '0;
    end else begin
      sat_q[0] <= sum_sat;
      for (int i = 1; i < ADD_LAT; i++) sat_q[i] <= sat_q[i-1];
    end
  end

  assign out_sat = out_valid && sat_q[ADD_LAT-1];
`else
  assign sum_res = sum_full;
`endif

  logic [ADD_LAT-1:0]             vld_q;
  logic [ADD_LAT-1:0][DWIDTH-1:0] dat_q;

  // Delay line so the result reaches the bank exactly ADD_LAT cycles after acceptance.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= sum_res;
      for (int i = 1; i < ADD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[ADD_LAT-1];
  assign out_data  = dat_q[ADD_LAT-1];

endmodule

// File: rtl/syncfifo.sv
// rtl/syncfifo.sv - single-clock FIFO with first-word fall-through read data
module syncfifo #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH:0]   wr_ptr_q;
  logic [AWIDTH:0]   rd_ptr_q;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                   (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AWIDTH-1:0]];

  // Storage array; contents are discarded logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (wr_en && !full) mem_q[wr_ptr_q[AWIDTH-1:0]] <= wr_data;
  end

  // Pointer update; writes to a full FIFO and reads of an empty one are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/psum_accum_pp.sv
// rtl/psum_accum_pp.sv - ping-pong partial-sum accumulator top (PSUM_SAT_EN enables saturation and sat_hit)
module psum_accum_pp
  import psum_accum_pp_pkg::*;
#(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 4,
  parameter int NPE     = 3,
  parameter int ADD_LAT = 2
) (
  input  logic           clk,
  input  logic           rstn,
  psum_accum_pp_if.slave bus
);
  localparam int WAIT_W = $clog2(ADD_LAT + 1);

  acc_state_e        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              in_ready_q;
  bank_e             acc_bank_q;
  logic              err_ovf_q;
  logic              err_unf_q;

  logic              acc_sel;
  logic              drain_sel;
  logic              accept;
  logic              fb_ok;
  logic              fb_pop;
  logic              unf_evt;
  logic              ovf_evt;
  logic              drain_pop;
  logic [DWIDTH-1:0] psum_in;
  logic              sum_valid;
  logic [DWIDTH-1:0] sum_data;

  logic [1:0]        bank_wr;
  logic [1:0]        bank_rd_en;
  logic [1:0]        bank_full;
  logic [1:0]        bank_empty;
  logic [DWIDTH-1:0] bank_rd [2];

  assign acc_sel   = (acc_bank_q == BANK_PONG);
  assign drain_sel = ~acc_sel;
  assign accept    = bus.data_valid && in_ready_q;

  // Later passes take the accumulating bank's head as psum; an empty bank contributes zero.
  assign fb_ok     = (state_q == ACCN) && !bank_empty[acc_sel];
  assign fb_pop    = accept && fb_ok;
  assign unf_evt   = accept && (state_q == ACCN) && bank_empty[acc_sel];
  assign psum_in   = fb_ok ? bank_rd[acc_sel] : '0;
  assign ovf_evt   = sum_valid && bank_full[acc_sel];
  assign drain_pop = !bank_empty[drain_sel] && bus.result_ready;

  psum_accum_pp_addtree #(
    .DWIDTH  (DWIDTH),
    .NPE     (NPE),
    .ADD_LAT (ADD_LAT)
  ) u_addtree (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (accept),
    .pe_data   (bus.pe_data),
    .psum_in   (psum_in),
    .out_valid (sum_valid),
`ifdef PSUM_SAT_EN
    .out_sat   (bus.sat_hit),
`endif
    .out_data  (sum_data)
  );

  // Route accumulation traffic to one bank and drain traffic to the other.
  always_comb begin
    bank_wr               = '0;
    bank_rd_en            = '0;
    bank_wr[acc_sel]      = sum_valid && !bank_full[acc_sel];
    bank_rd_en[acc_sel]   = fb_pop;
    bank_rd_en[drain_sel] = drain_pop;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    syncfifo #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (bank_wr[b]),
      .wr_data (sum_data),
      .rd_en   (bank_rd_en[b]),
      .rd_data (bank_rd[b]),
      .full    (bank_full[b]),
      .empty   (bank_empty[b])
    );
  end

  // Pass controller: stalls input while sums are in flight and swaps banks once the drain side is empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ACC1;
      wait_q     <= '0;
      in_ready_q <= 1'b0;
      acc_bank_q <= BANK_PING;
    end else begin
      case (state_q)
        ACC1, ACCN: begin
          if (!in_ready_q) begin
            if (wait_q > WAIT_W'(1)) begin
              wait_q <= wait_q - WAIT_W'(1);
            end else begin
              wait_q     <= '0;
              in_ready_q <= 1'b1;
            end
          end else if (bus.oc_done) begin
            state_q    <= FLUSH;
            wait_q     <= WAIT_W'(ADD_LAT - 1);
            in_ready_q <= 1'b0;
          end else if (bus.ic_done) begin
            // Hold off the next pass until the last write of this one has landed.
            state_q    <= ACCN;
            wait_q     <= WAIT_W'(ADD_LAT);
            in_ready_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (wait_q == '0) state_q <= SWAP;
          else              wait_q  <= wait_q - WAIT_W'(1);
        end
        SWAP: begin
          if (bank_empty[drain_sel]) begin
            acc_bank_q <= other_bank(acc_bank_q);
            state_q    <= ACC1;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= ACC1;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      if (ovf_evt)          err_ovf_q <= 1'b1;
      else if (bus.err_clr) err_ovf_q <= 1'b0;
      if (unf_evt)          err_unf_q <= 1'b1;
      else if (bus.err_clr) err_unf_q <= 1'b0;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.result_valid = !bank_empty[drain_sel];
  assign bus.result       = bank_empty[drain_sel] ? '0 : bank_rd[drain_sel];
  assign bus.acc_bank     = acc_sel;
  assign bus.err_ovf      = err_ovf_q;
  assign bus.err_unf      = err_unf_q;

endmodule

// File: tb/tb_psum_accum_pp.sv
// tb/tb_psum_accum_pp.sv - directed self-checking bench for psum_accum_pp (PSUM_SAT_EN selects saturation expectations)
module tb_psum_accum_pp;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  always #5 clk = ~clk;

  psum_accum_pp_if #(.DWIDTH(32), .NPE(3)) bus ();

  psum_accum_pp #(
    .DWIDTH  (32),
    .AWIDTH  (2),
    .NPE     (3),
    .ADD_LAT (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];

`ifdef PSUM_SAT_EN
  int sat_cnt = 0;
  always @(posedge clk) if (bus.sat_hit === 1'b1) sat_cnt++;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    wait_ready();
    bus.pe_data    = {c, b, a};
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.pe_data    = '0;
  endtask

  task automatic done(input bit oc);
    wait_ready();
    if (oc) bus.oc_done = 1'b1;
    else    bus.ic_done = 1'b1;
    @(negedge clk);
    bus.oc_done = 1'b0;
    bus.ic_done = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.result_ready = 1'b1;
    while (exp_q.size() > 0) begin
      n = 0;
      while (bus.result_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (bus.result_valid !== 1'b1) begin
        check("result_valid_timeout", 32'(bus.result_valid), 32'd1);
        exp_q.delete();
      end else begin
        check("result", bus.result, exp_q.pop_front());
        @(negedge clk);
      end
    end
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.data_valid   = 1'b0;
    bus.ic_done      = 1'b0;
    bus.oc_done      = 1'b0;
    bus.pe_data      = '0;
    bus.result_ready = 1'b0;
    bus.err_clr      = 1'b0;
    idle(3);

    check("rst_in_ready",     32'(bus.in_ready),     32'd0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result",       bus.result,            32'd0);
    check("rst_acc_bank",     32'(bus.acc_bank),     32'd0);
    check("rst_err_ovf",      32'(bus.err_ovf),      32'd0);
    check("rst_err_unf",      32'(bus.err_unf),      32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    // T1: single pass of 4 beats, each sums to 6
    repeat (4) beat(32'd1, 32'd2, 32'd3);
    done(1'b1);
    repeat (4) exp_q.push_back(32'd6);
    drain();
    check("t1_valid_after", 32'(bus.result_valid), 32'd0);
    check("t1_acc_bank",    32'(bus.acc_bank),     32'd1);

    // T2: three passes of 3 accumulate to 9
    for (int p = 0; p < 3; p++) begin
      repeat (4) beat(32'd1, 32'd1, 32'd1);
      if (p < 2) done(1'b0);
    end
    done(1'b1);
    repeat (4) exp_q.push_back(32'd9);
    drain();
    check("t2_err_unf",     32'(bus.err_unf),      32'd0);
    check("t2_acc_bank",    32'(bus.acc_bank),     32'd0);
    check("t2_valid_after", 32'(bus.result_valid), 32'd0);

    // T3: consumer stalled across a second oc_done
    bus.result_ready = 1'b0;
    repeat (4) beat(32'd2, 32'd0, 32'd0);
    done(1'b1);
    repeat (4) beat(32'd0, 32'd5, 32'd0);
    done(1'b1);
    idle(8);
    check("t3_in_ready_held", 32'(bus.in_ready),     32'd0);
    check("t3_acc_bank_held", 32'(bus.acc_bank),     32'd1);
    check("t3_valid_held",    32'(bus.result_valid), 32'd1);
    check("t3_head",          bus.result,            32'd2);
    repeat (4) exp_q.push_back(32'd2);
    repeat (4) exp_q.push_back(32'd5);
    drain();
    check("t3_acc_bank",    32'(bus.acc_bank),     32'd0);
    check("t3_valid_after", 32'(bus.result_valid), 32'd0);

    // T4: five beats into a 4-deep bank
    for (int k = 1; k <= 5; k++) beat(32'(k), 32'd0, 32'd0);
    done(1'b1);
    idle(3);
    check("t4_err_ovf_set", 32'(bus.err_ovf), 32'd1);
    for (int k = 1; k <= 4; k++) exp_q.push_back(32'(k));
    drain();
    check("t4_valid_after", 32'(bus.result_valid), 32'd0);
    pulse_clr();
    check("t4_err_ovf_clr", 32'(bus.err_ovf), 32'd0);
    check("t4_err_unf",     32'(bus.err_unf), 32'd0);

    // T5: empty first pass forces feedback from an empty bank, then a wrapping/saturating sum
    done(1'b0);
    beat(32'h7FFF_FFFF, 32'd1, 32'd0);
    done(1'b1);
    idle(2);
    check("t5_err_unf_set", 32'(bus.err_unf), 32'd1);
`ifdef PSUM_SAT_EN
    exp_q.push_back(32'h7FFF_FFFF);
`else
    exp_q.push_back(32'h8000_0000);
`endif
    drain();
`ifdef PSUM_SAT_EN
    check("t5_sat_hit_count", 32'(sat_cnt), 32'd1);
`endif
    check("t5_acc_bank", 32'(bus.acc_bank), 32'd0);

    // T6: reset in the middle of a drain
    repeat (5) beat(32'd1, 32'd2, 32'd3);
    done(1'b1);
    exp_q.push_back(32'd6);
    exp_q.push_back(32'd6);
    drain();
    check("t6_valid_pre",    32'(bus.result_valid), 32'd1);
    check("t6_acc_bank_pre", 32'(bus.acc_bank),     32'd1);
    check("t6_err_ovf_pre",  32'(bus.err_ovf),      32'd1);
    rstn = 1'b0;
    #1;
    check("t6_rst_valid",    32'(bus.result_valid), 32'd0);
    check("t6_rst_acc_bank", 32'(bus.acc_bank),     32'd0);
    check("t6_rst_err_ovf",  32'(bus.err_ovf),      32'd0);
    check("t6_rst_err_unf",  32'(bus.err_unf),      32'd0);
    check("t6_rst_in_ready", 32'(bus.in_ready),     32'd0);
    bus.result_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (4) beat(32'd1, 32'd2, 32'd3);
    done(1'b1);
    repeat (4) exp_q.push_back(32'd6);
    drain();
    check("t6_valid_after", 32'(bus.result_valid), 32'd0);
    check("t6_acc_bank",    32'(bus.acc_bank),     32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
